sipo_stream: RTL and testbench

//   Parametrised serial-in/parallel-out deserialiser. Successor to the fixed 8-bit SIPO.

---
 rtl/sipo_stream_pkg.sv | 28 ++
 rtl/sipo_out_stage.sv | 72 +++++++
 rtl/sipo_stream.sv | 92 +++++++++
 tb/tb_sipo_stream.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_stream_pkg.sv
// Shared definitions for the serial/parallel stream blocks: width helpers
// used to size the bit counter from the word width.
package sipo_stream_pkg;

  // Ceiling log2 of a positive value (clog2(1) = 0).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

  // Width of a counter that holds 0 .. width-1, never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    int unsigned bits;
    bits = clog2(width);
    if (bits < 1) begin
      bits = 1;
    end
    return bits;
  endfunction

endpackage : sipo_stream_pkg

// File: rtl/sipo_out_stage.sv
// One-word output hold register with valid/ready handshake.
// A word offered while an unconsumed word is still held (and not being
// drained on the same edge) is dropped and raises the sticky overrun flag.
module sipo_out_stage #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             out_ready_i,
  input  logic             ovr_clr_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  output logic             overrun_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             drain;
  logic             accept;
  logic             drop;

  // Handshake decode and next state of the hold register and overrun flag.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    // out_ready only matters while a word is actually held.
    drain   = valid_q & out_ready_i;
    accept  = load_valid_i & (~valid_q | out_ready_i);
    drop    = load_valid_i & valid_q & ~out_ready_i;

    if (accept) begin
      data_d  = load_data_i;
      valid_d = 1'b1;
    end else if (drain) begin
      // Consumed with nothing new: data is kept, only valid drops.
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    // A drop on the same edge as ovr_clr wins.
    if (drop) begin
      ovr_d = 1'b1;
    end else if (ovr_clr_i) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // Hold register, valid flag and sticky overrun state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_data_o  = data_q;
  assign out_valid_o = valid_q;
  assign overrun_o   = ovr_q;

endmodule : sipo_out_stage

// File: rtl/sipo_stream.sv
// Parametrised serial-in/parallel-out deserialiser. Collects WIDTH bits
// framed by in_valid, in selectable bit order, and hands each completed word
// to a one-word valid/ready output stage so shifting never stalls.
module sipo_stream
  import sipo_stream_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b1,
  localparam int unsigned CNT_W    = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic             serial_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun,
  input  logic             ovr_clr
);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_in;
  logic             last_bit;
  logic             complete;

  // Shifter and bit counter next state; detects the word-completing edge.
  always_comb begin
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    complete = 1'b0;

    // LSB-first shifts right so the first bit ends up in bit 0 after WIDTH
    // shifts; MSB-first shifts left so it ends up in bit WIDTH-1.
    if (LSB_FIRST) begin
      shift_in = {serial_in, shift_q[WIDTH-1:1]};
    end else begin
      shift_in = {shift_q[WIDTH-2:0], serial_in};
    end

    last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    if (clr) begin
      // Abort beats a bit sampled on the same edge, including a completion.
      shift_d = '0;
      cnt_d   = '0;
    end else if (in_valid) begin
      shift_d = shift_in;
      if (last_bit) begin
        cnt_d    = '0;
        complete = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
    end
  end

  // Shift register and bit counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // The offered word includes the bit sampled on the completing edge.
  sipo_out_stage #(
    .WIDTH(WIDTH)
  ) u_out_stage (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_valid_i (complete),
    .load_data_i  (shift_in),
    .out_ready_i  (out_ready),
    .ovr_clr_i    (ovr_clr),
    .out_data_o   (out_data),
    .out_valid_o  (out_valid),
    .overrun_o    (overrun)
  );

  assign bit_cnt = cnt_q;

endmodule : sipo_stream

// File: tb/tb_sipo_stream.sv
// Self-checking bench for sipo_stream: three instances (WIDTH=8 LSB-first,
// WIDTH=8 MSB-first, WIDTH=5 LSB-first) share one stimulus stream and are
// compared against a bit-queue reference model plus directed expectations.
module tb_sipo_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, clr, in_valid, serial_in, out_ready, ovr_clr;
  logic [7:0] d8l, d8m;
  logic [4:0] d5;
  logic       v8l, v8m, v5;
  logic [2:0] c8l, c8m, c5;
  logic       o8l, o8m, o5;

  sipo_stream #(.WIDTH(8), .LSB_FIRST(1'b1)) u_l8 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .serial_in(serial_in),
    .out_data(d8l), .out_valid(v8l), .out_ready(out_ready), .bit_cnt(c8l),
    .overrun(o8l), .ovr_clr(ovr_clr));

  sipo_stream #(.WIDTH(8), .LSB_FIRST(1'b0)) u_m8 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .serial_in(serial_in),
    .out_data(d8m), .out_valid(v8m), .out_ready(out_ready), .bit_cnt(c8m),
    .overrun(o8m), .ovr_clr(ovr_clr));

  sipo_stream #(.WIDTH(5), .LSB_FIRST(1'b1)) u_l5 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .serial_in(serial_in),
    .out_data(d5), .out_valid(v5), .out_ready(out_ready), .bit_cnt(c5),
    .overrun(o5), .ovr_clr(ovr_clr));

  logic [7:0] dout [3];
  logic       dval [3];
  logic [2:0] dcnt [3];
  logic       dovr [3];

  always_comb begin
    dout[0] = d8l;  dval[0] = v8l;  dcnt[0] = c8l;  dovr[0] = o8l;
    dout[1] = d8m;  dval[1] = v8m;  dcnt[1] = c8m;  dovr[1] = o8m;
    dout[2] = {3'b000, d5};  dval[2] = v5;  dcnt[2] = c5;  dovr[2] = o5;
  end

  // Reference model: collected bits are kept as a queue; a word is formed
  // arithmetically once the queue holds WIDTH bits.
  int         mw   [3] = '{8, 8, 5};
  bit         mlsb [3] = '{1'b1, 1'b0, 1'b1};
  bit         mq   [3][$];
  logic [7:0] mdata[3];
  bit         mvalid[3];
  bit         movr [3];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mq[i].delete();
      mdata[i]  = 8'h00;
      mvalid[i] = 1'b0;
      movr[i]   = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      bit done;
      bit drop;
      logic [7:0] w;
      done = 1'b0;
      w    = 8'h00;
      if (clr) begin
        mq[i].delete();
      end else if (in_valid) begin
        mq[i].push_back(serial_in);
        if (mq[i].size() == mw[i]) begin
          for (int k = 0; k < mw[i]; k++) begin
            if (mlsb[i]) w[k] = mq[i][k];
            else         w[mw[i] - 1 - k] = mq[i][k];
          end
          done = 1'b1;
          mq[i].delete();
        end
      end
      drop = done && mvalid[i] && !out_ready;
      if (ovr_clr) movr[i] = 1'b0;
      if (drop)    movr[i] = 1'b1;
      if (done && !drop) begin
        mdata[i]  = w;
        mvalid[i] = 1'b1;
      end else if (!done && mvalid[i] && out_ready) begin
        mvalid[i] = 1'b0;
      end
    end
  endtask

  // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
  task automatic cyc(input logic v, input logic b, input logic r, input logic c, input logic oc);
    in_valid  = v;
    serial_in = b;
    out_ready = r;
    clr       = c;
    ovr_clr   = oc;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; serial_in = 1'b0; out_ready = 1'b0; ovr_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (dval[i] !== 1'b0 || dout[i] !== 8'h00 || dcnt[i] !== 3'd0 || dovr[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset[%0d]: got v=%b d=%h cnt=%0d ovr=%b, expected all zero", i, dval[i], dout[i], dcnt[i], dovr[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_bit_order();
    logic [7:0] pat;
    pat = 8'hB3;  // pat[k] is the k-th bit sent: 1,1,0,0,1,1,0,1
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, pat[k], 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (dval[i] !== mvalid[i] || dout[i] !== mdata[i] || dcnt[i] !== 3'(mq[i].size()) || dovr[i] !== movr[i]) begin
          n_fail++;
          $display("FAIL bit_order[%0d] k=%0d: got v=%b d=%h cnt=%0d ovr=%b, expected v=%b d=%h cnt=%0d ovr=%b",
                   i, k, dval[i], dout[i], dcnt[i], dovr[i], mvalid[i], mdata[i], mq[i].size(), movr[i]);
        end
      end
    end
    n_checks++;
    if (dval[0] !== 1'b1 || dout[0] !== 8'hB3 || dovr[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL lsb_first_word: got v=%b d=%h ovr=%b, expected v=1 d=b3 ovr=0", dval[0], dout[0], dovr[0]);
    end
    n_checks++;
    if (dval[1] !== 1'b1 || dout[1] !== 8'hCD) begin
      n_fail++;
      $display("FAIL msb_first_word: got v=%b d=%h, expected v=1 d=cd", dval[1], dout[1]);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (dval[0] !== 1'b0 || dval[1] !== 1'b0 || dout[0] !== 8'hB3) begin
      n_fail++;
      $display("FAIL valid_pulse: got v0=%b v1=%b d0=%h, expected v0=0 v1=0 d0=b3", dval[0], dval[1], dout[0]);
    end
    // Realign the 5-bit instance, which holds a partial word.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (dval[i] !== mvalid[i] || dout[i] !== mdata[i] || dcnt[i] !== 3'(mq[i].size()) || dovr[i] !== movr[i]) begin
        n_fail++;
        $display("FAIL bit_order_clr[%0d]: got v=%b d=%h cnt=%0d ovr=%b, expected v=%b d=%h cnt=%0d ovr=%b",
                 i, dval[i], dout[i], dcnt[i], dovr[i], mvalid[i], mdata[i], mq[i].size(), movr[i]);
      end
    end
  endtask

  task automatic test_overrun();
    logic [15:0] stream;
    stream = {8'h3C, 8'hA5};  // A5 first, LSB first
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, stream[k], 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (dval[i] !== mvalid[i] || dout[i] !== mdata[i] || dcnt[i] !== 3'(mq[i].size()) || dovr[i] !== movr[i]) begin
          n_fail++;
          $display("FAIL overrun[%0d] k=%0d: got v=%b d=%h cnt=%0d ovr=%b, expected v=%b d=%h cnt=%0d ovr=%b",
                   i, k, dval[i], dout[i], dcnt[i], dovr[i], mvalid[i], mdata[i], mq[i].size(), movr[i]);
        end
      end
    end
    n_checks++;
    if (dval[0] !== 1'b1 || dout[0] !== 8'hA5 || dovr[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_hold: got v=%b d=%h ovr=%b, expected v=1 d=a5 ovr=1", dval[0], dout[0], dovr[0]);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (dval[0] !== 1'b0 || dout[0] !== 8'hA5 || dovr[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_drain: got v=%b d=%h ovr=%b, expected v=0 d=a5 ovr=1", dval[0], dout[0], dovr[0]);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (dovr[0] !== 1'b0 || dovr[1] !== 1'b0 || dovr[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_clr: got ovr=%b%b%b, expected 000", dovr[0], dovr[1], dovr[2]);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_gap();
    logic [7:0] w;
    w = 8'h5A;
    for (int k = 0; k < 3; k++) cyc(1'b1, w[k], 1'b0, 1'b0, 1'b0);
    for (int g = 0; g < 5; g++) begin
      cyc(1'b0, 1'($urandom_range(1, 0)), 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (dcnt[0] !== 3'd3 || dcnt[1] !== 3'd3) begin
        n_fail++;
        $display("FAIL gap_hold g=%0d: got cnt=%0d/%0d, expected 3", g, dcnt[0], dcnt[1]);
      end
    end
    for (int k = 3; k < 8; k++) cyc(1'b1, w[k], 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (dval[0] !== 1'b1 || dout[0] !== 8'h5A || dcnt[0] !== 3'd0) begin
      n_fail++;
      $display("FAIL gap_word: got v=%b d=%h cnt=%0d, expected v=1 d=5a cnt=0", dval[0], dout[0], dcnt[0]);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (dval[i] !== mvalid[i] || dout[i] !== mdata[i] || dcnt[i] !== 3'(mq[i].size()) || dovr[i] !== movr[i]) begin
        n_fail++;
        $display("FAIL gap[%0d]: got v=%b d=%h cnt=%0d ovr=%b, expected v=%b d=%h cnt=%0d ovr=%b",
                 i, dval[i], dout[i], dcnt[i], dovr[i], mvalid[i], mdata[i], mq[i].size(), movr[i]);
      end
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_reset_clr();
    logic [7:0] w1;
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'($urandom_range(1, 0)), 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (dval[i] !== 1'b0 || dout[i] !== 8'h00 || dcnt[i] !== 3'd0 || dovr[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL async_reset[%0d]: got v=%b d=%h cnt=%0d ovr=%b, expected all zero", i, dval[i], dout[i], dcnt[i], dovr[i]);
      end
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    w1 = 8'($urandom());
    for (int k = 0; k < 8; k++) cyc(1'b1, w1[k], 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (dval[0] !== 1'b1 || dout[0] !== w1) begin
      n_fail++;
      $display("FAIL post_reset_word: got v=%b d=%h, expected v=1 d=%h", dval[0], dout[0], w1);
    end
    for (int k = 0; k < 6; k++) cyc(1'b1, 1'($urandom_range(1, 0)), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (dcnt[0] !== 3'd0 || dval[0] !== 1'b1 || dout[0] !== w1) begin
      n_fail++;
      $display("FAIL clr_keeps_word: got cnt=%0d v=%b d=%h, expected cnt=0 v=1 d=%h", dcnt[0], dval[0], dout[0], w1);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (dval[i] !== mvalid[i] || dout[i] !== mdata[i] || dcnt[i] !== 3'(mq[i].size()) || dovr[i] !== movr[i]) begin
        n_fail++;
        $display("FAIL reset_clr[%0d]: got v=%b d=%h cnt=%0d ovr=%b, expected v=%b d=%h cnt=%0d ovr=%b",
                 i, dval[i], dout[i], dcnt[i], dovr[i], mvalid[i], mdata[i], mq[i].size(), movr[i]);
      end
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [15:0] ws;
    logic [7:0]  got [$];
    logic        rdy;
    ws = 16'($urandom());
    for (int s = 0; s < 16; s++) begin
      rdy = (s == 15) ? 1'b1 : ((s < 8) ? 1'b1 : 1'b0);
      cyc(1'b1, ws[s], rdy, 1'b0, 1'b0);
      if (s == 7 || s == 15) got.push_back(dout[0]);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (dval[i] !== mvalid[i] || dout[i] !== mdata[i] || dcnt[i] !== 3'(mq[i].size()) || dovr[i] !== movr[i]) begin
          n_fail++;
          $display("FAIL back_to_back[%0d] s=%0d: got v=%b d=%h cnt=%0d ovr=%b, expected v=%b d=%h cnt=%0d ovr=%b",
                   i, s, dval[i], dout[i], dcnt[i], dovr[i], mvalid[i], mdata[i], mq[i].size(), movr[i]);
        end
      end
    end
    n_checks++;
    if (got.size() != 2 || got[0] !== ws[7:0] || got[1] !== ws[15:8] || dval[0] !== 1'b1 || dovr[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_order: got %h,%h v=%b ovr=%b, expected %h,%h v=1 ovr=0",
               got[0], got[1], dval[0], dovr[0], ws[7:0], ws[15:8]);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      cyc(1'($urandom_range(99, 0) < 75), 1'($urandom_range(1, 0)), 1'($urandom_range(99, 0) < 40),
          1'($urandom_range(99, 0) < 3), 1'($urandom_range(99, 0) < 10));
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (dval[i] !== mvalid[i] || dout[i] !== mdata[i] || dcnt[i] !== 3'(mq[i].size()) || dovr[i] !== movr[i]) begin
          n_fail++;
          $display("FAIL random[%0d] n=%0d: got v=%b d=%h cnt=%0d ovr=%b, expected v=%b d=%h cnt=%0d ovr=%b",
                   i, n, dval[i], dout[i], dcnt[i], dovr[i], mvalid[i], mdata[i], mq[i].size(), movr[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_bit_order();
    test_overrun();
    test_gap();
    test_reset_clr();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

endmodule : tb_sipo_stream
